// File: rtl/lcd_pkg.sv
// Shared types and panel timing constants for the RGB-LCD timing generator.
// Optional build macro LCD_DE_MODE_EN is consumed by lcd_driver.sv.
package lcd_pkg;

    localparam int LCD_ID_W  = 16;
    localparam int LCD_CNT_W = 11;
    localparam int LCD_RGB_W = 24;

    typedef struct packed {
        logic [LCD_CNT_W-1:0] hsync;
        logic [LCD_CNT_W-1:0] hback;
        logic [LCD_CNT_W-1:0] hdisp;
        logic [LCD_CNT_W-1:0] hfront;
        logic [LCD_CNT_W-1:0] htotal;
        logic [LCD_CNT_W-1:0] vsync;
        logic [LCD_CNT_W-1:0] vback;
        logic [LCD_CNT_W-1:0] vdisp;
        logic [LCD_CNT_W-1:0] vfront;
        logic [LCD_CNT_W-1:0] vtotal;
    } timing_t;

    localparam logic [LCD_ID_W-1:0] ID_4342 = 16'h4342;
    localparam logic [LCD_ID_W-1:0] ID_7084 = 16'h7084;
    localparam logic [LCD_ID_W-1:0] ID_4384 = 16'h4384;
    localparam logic [LCD_ID_W-1:0] ID_7016 = 16'h7016;
    localparam logic [LCD_ID_W-1:0] ID_1018 = 16'h1018;

    localparam timing_t TIMING_INVALID = '0;

    function automatic timing_t mk_timing(input int hs, input int hb, input int hd,
                                          input int hf, input int ht, input int vs,
                                          input int vb, input int vd, input int vf,
                                          input int vt);
        timing_t t;
        t.hsync  = LCD_CNT_W'(hs);
        t.hback  = LCD_CNT_W'(hb);
        t.hdisp  = LCD_CNT_W'(hd);
        t.hfront = LCD_CNT_W'(hf);
        t.htotal = LCD_CNT_W'(ht);
        t.vsync  = LCD_CNT_W'(vs);
        t.vback  = LCD_CNT_W'(vb);
        t.vdisp  = LCD_CNT_W'(vd);
        t.vfront = LCD_CNT_W'(vf);
        t.vtotal = LCD_CNT_W'(vt);
        return t;
    endfunction

endpackage

// File: rtl/lcd_driver_if.sv
// Signal bundle between lcd_driver (master) and its pixel source / panel (slave).
interface lcd_driver_if #(
    parameter int ID_W  = 16,
    parameter int CNT_W = 11,
    parameter int RGB_W = 24
);
    // Request/return contract: data_req with pixel_xpos/ypos asks for a pixel;
    // the source answers on pixel_data exactly one cycle later, aligned with lcd_de.
    // There is no back-pressure: a request is never held or repeated.
    logic [ID_W-1:0]  lcd_id;
    logic [RGB_W-1:0] pixel_data;
    logic             data_req;
    logic [CNT_W-1:0] pixel_xpos;
    logic [CNT_W-1:0] pixel_ypos;
    logic [CNT_W-1:0] h_disp;
    logic [CNT_W-1:0] v_disp;
    logic             lcd_hs;
    logic             lcd_vs;
    logic             lcd_de;
    logic [RGB_W-1:0] lcd_rgb;
    logic             lcd_bl;
    logic             lcd_rst;

    modport master (
        input  lcd_id, pixel_data,
        output data_req, pixel_xpos, pixel_ypos, h_disp, v_disp,
               lcd_hs, lcd_vs, lcd_de, lcd_rgb, lcd_bl, lcd_rst
    );

    modport slave (
        output lcd_id, pixel_data,
        input  data_req, pixel_xpos, pixel_ypos, h_disp, v_disp,
               lcd_hs, lcd_vs, lcd_de, lcd_rgb, lcd_bl, lcd_rst
    );
endinterface

// File: rtl/lcd_timing_rom.sv
// Combinational panel-ID to timing-set lookup; unknown IDs yield all-zero timing.
module lcd_timing_rom
    import lcd_pkg::*;
#(
    parameter int ID_W = LCD_ID_W
) (
    input  logic [ID_W-1:0] id_i,
    output timing_t         timing_o,
    output logic            valid_o
);

    always_comb begin
        timing_o = TIMING_INVALID;
        valid_o  = 1'b1;
        case (id_i)
            ID_4342:          timing_o = mk_timing(41, 2, 480, 2, 525, 10, 2, 272, 2, 286);
            ID_7084, ID_4384: timing_o = mk_timing(128, 88, 800, 40, 1056, 2, 33, 480, 10, 525);
            ID_7016:          timing_o = mk_timing(20, 140, 1024, 160, 1344, 3, 20, 600, 12, 635);
            ID_1018:          timing_o = mk_timing(10, 80, 1280, 70, 1440, 3, 10, 800, 10, 823);
            default:          valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/lcd_driver.sv
// RGB-LCD timing generator: ID-selected h/v counters, sync/DE decode, pixel request.
// Build macro LCD_DE_MODE_EN ties lcd_hs/lcd_vs high for DE-only panels.
module lcd_driver
    import lcd_pkg::*;
#(
    parameter int ID_W  = 16,
    parameter int CNT_W = 11,
    parameter int RGB_W = 24
) (
    input  logic         lcd_pclk,
    input  logic         rst,
    lcd_driver_if.master bus
);

    logic [ID_W-1:0]  id_q, id_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             pwr_q;

    timing_t tm;
    logic    tm_valid;

    lcd_timing_rom #(.ID_W(ID_W)) u_rom (
        .id_i     (id_q),
        .timing_o (tm),
        .valid_o  (tm_valid)
    );

    logic h_end, v_end;
    assign h_end = (h_q == tm.htotal - CNT_W'(1));
    assign v_end = (v_q == tm.vtotal - CNT_W'(1));

    // An invalid latched ID keeps re-sampling; a valid one only changes between frames.
    always_comb begin
        id_d = id_q;
        h_d  = '0;
        v_d  = '0;
        if (!tm_valid) begin
            id_d = bus.lcd_id;
        end else begin
            h_d = h_end ? '0 : h_q + CNT_W'(1);
            v_d = v_q;
            if (h_end) begin
                v_d = v_end ? '0 : v_q + CNT_W'(1);
                if (v_end) id_d = bus.lcd_id;
            end
        end
    end

    always_ff @(posedge lcd_pclk or posedge rst) begin
        if (rst) begin
            id_q  <= '0;
            h_q   <= '0;
            v_q   <= '0;
            pwr_q <= 1'b0;
        end else begin
            id_q  <= id_d;
            h_q   <= h_d;
            v_q   <= v_d;
            pwr_q <= 1'b1;
        end
    end

    logic [CNT_W-1:0] h_start, h_stop, v_start, v_stop, h_next;
    logic             v_win, de, req;

    assign h_start = tm.hsync + tm.hback;
    assign h_stop  = h_start + tm.hdisp;
    assign v_start = tm.vsync + tm.vback;
    assign v_stop  = v_start + tm.vdisp;
    assign h_next  = h_q + CNT_W'(1);

    assign v_win = tm_valid && (v_q >= v_start) && (v_q < v_stop);
    assign de    = v_win && (h_q >= h_start) && (h_q < h_stop);
    // Request leads DE by one cycle so the source's registered pixel lands in the window.
    assign req   = v_win && (h_next >= h_start) && (h_next < h_stop);

    assign bus.lcd_de     = de;
    assign bus.data_req   = req;
    assign bus.pixel_xpos = req ? (h_next - h_start) : '0;
    assign bus.pixel_ypos = req ? (v_q - v_start) : '0;
    assign bus.lcd_rgb    = de ? bus.pixel_data : '0;
    assign bus.h_disp     = tm.hdisp;
    assign bus.v_disp     = tm.vdisp;
    assign bus.lcd_bl     = pwr_q;
    assign bus.lcd_rst    = pwr_q;

`ifdef LCD_DE_MODE_EN
    assign bus.lcd_hs = 1'b1;
    assign bus.lcd_vs = 1'b1;
`else
    assign bus.lcd_hs = !(tm_valid && (h_q < tm.hsync));
    assign bus.lcd_vs = !(tm_valid && (v_q < tm.vsync));
`endif

    // Front porches are implied by the totals and are not needed by the decode.
    logic unused_front;
    assign unused_front = ^{tm.hfront, tm.vfront};

endmodule
